// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: pipelined ibus reads with credit-based issue into a
// DEPTH-entry PC/instruction queue; redirects flush the queue and kill in-flight reads.
module fetch_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Handshakes: an ibus request transfers on ireq_valid & iresp_addr_ok and is held
    // unchanged until then; a queue entry transfers to decode on out_valid & out_ready.

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [OW-1:0] kill_cnt_q, kill_cnt_d;
    logic          kill_req_q, kill_req_d;
    logic [31:0]   pend_pc_q [MAX_OUTSTANDING];
    logic [PW-1:0] pend_rd_q, pend_rd_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic [AW-1:0] q_rd_q, q_rd_d;
    logic [AW-1:0] q_wr_q, q_wr_d;

    logic accept;
    logic push;
    logic pop;
    logic credit_ok;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
    endfunction

    assign accept = req_valid_q & iresp_addr_ok;
    assign pop    = (q_cnt_q != '0) & out_ready;
    // Words returning in a redirect cycle or owed to an earlier redirect are discarded.
    assign push   = iresp_data_ok & (kill_cnt_q == '0) & ~redirect_valid;

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (accept)        out_cnt_d = out_cnt_d + OW'(1);
        if (iresp_data_ok) out_cnt_d = out_cnt_d - OW'(1);

        kill_cnt_d = kill_cnt_q;
        if (accept && kill_req_q)                   kill_cnt_d = kill_cnt_d + OW'(1);
        if (iresp_data_ok && (kill_cnt_q != '0))    kill_cnt_d = kill_cnt_d - OW'(1);
        if (redirect_valid)                         kill_cnt_d = out_cnt_d;

        kill_req_d = kill_req_q;
        if (accept) kill_req_d = 1'b0;
        if (redirect_valid && req_valid_q && !iresp_addr_ok) kill_req_d = 1'b1;

        pend_wr_d = accept        ? pend_inc(pend_wr_q) : pend_wr_q;
        pend_rd_d = iresp_data_ok ? pend_inc(pend_rd_q) : pend_rd_q;

        q_cnt_d = q_cnt_q;
        q_rd_d  = q_rd_q;
        q_wr_d  = q_wr_q;
        if (push) begin
            q_cnt_d = q_cnt_d + CW'(1);
            q_wr_d  = q_wr_q + AW'(1);
        end
        if (pop) begin
            q_cnt_d = q_cnt_d - CW'(1);
            q_rd_d  = q_rd_q + AW'(1);
        end
        if (redirect_valid) begin
            q_cnt_d = '0;
            q_rd_d  = '0;
            q_wr_d  = '0;
        end

        // A killed request was issued for the old stream, so it does not advance fetch_pc.
        fetch_pc_d = fetch_pc_q;
        if (accept && !kill_req_q) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect_valid)        fetch_pc_d = redirect_pc;

        // Every accepted read must have a guaranteed queue slot when it returns.
        credit_ok = (int'(out_cnt_d) < MAX_OUTSTANDING) &&
                    ((int'(q_cnt_d) + int'(out_cnt_d)) < DEPTH);

        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        if (!req_valid_q || accept) begin
            req_valid_d = credit_ok;
            if (credit_ok) req_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            out_cnt_q   <= '0;
            kill_cnt_q  <= '0;
            kill_req_q  <= 1'b0;
            pend_rd_q   <= '0;
            pend_wr_q   <= '0;
            q_cnt_q     <= '0;
            q_rd_q      <= '0;
            q_wr_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) pend_pc_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            out_cnt_q   <= out_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
            kill_req_q  <= kill_req_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            q_cnt_q     <= q_cnt_d;
            q_rd_q      <= q_rd_d;
            q_wr_q      <= q_wr_d;
            if (accept) pend_pc_q[pend_wr_q] <= req_addr_q;
            if (push) begin
                q_pc_q[q_wr_q]    <= pend_pc_q[pend_rd_q];
                q_instr_q[q_wr_q] <= iresp_data;
            end
        end
    end

    assign ireq_valid = req_valid_q;
    assign ireq_addr  = req_addr_q;
    assign out_valid  = (q_cnt_q != '0);
    assign out_pc     = q_pc_q[q_rd_q];
    assign out_instr  = q_instr_q[q_rd_q];

    a_no_orphan_data: assert property (@(posedge clk) disable iff (reset)
        !(iresp_data_ok && (out_cnt_q == '0)));
    a_no_queue_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (q_cnt_q == CW'(DEPTH))));
    a_kill_le_outstanding: assert property (@(posedge clk) disable iff (reset)
        kill_cnt_q <= out_cnt_q);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: an in-order ibus responder with one-cycle
// data latency plus hand-computed expected PCs for streaming, backpressure and redirects.
module tb_fetch_prefetch_queue;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bus_q [$];
    logic [31:0] exp_q [$];
    bit          addr_ok_mode;
    bit          auto_resp;

    fetch_prefetch_queue #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (RST_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h0ff0_5aa5;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive_resp();
        if (auto_resp && (bus_q.size() > 0)) begin
            iresp_data_ok = 1'b1;
            iresp_data    = instr_of(bus_q[0]);
        end else begin
            iresp_data_ok = 1'b0;
            iresp_data    = '0;
        end
    endtask

    task automatic set_addr_ok(input bit b);
        addr_ok_mode  = b;
        iresp_addr_ok = b;
    endtask

    // One clock: record bus events of the ending cycle, then drive the next cycle.
    task automatic tick();
        logic        acc;
        logic        dok;
        logic [31:0] a;
        acc = ireq_valid && iresp_addr_ok && !reset;
        dok = iresp_data_ok && !reset;
        a   = ireq_addr;
        @(posedge clk);
        #1;
        if (dok && (bus_q.size() > 0)) void'(bus_q.pop_front());
        if (acc) bus_q.push_back(a);
        iresp_addr_ok  = addr_ok_mode;
        redirect_valid = 1'b0;
        drive_resp();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        auto_resp      = 1'b0;
        addr_ok_mode   = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        bus_q.delete();
        tick();
        tick();
        check_val("rst_ireq_valid", ireq_valid, 0);
        check_val("rst_ireq_addr", ireq_addr, RST_PC);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_pc", out_pc, 0);
        check_val("rst_out_instr", out_instr, 0);
        reset = 1'b0;
    endtask

    initial begin
        // Streaming at one word per cycle.
        do_reset();
        set_addr_ok(1);
        auto_resp = 1;
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("t1_req_valid", ireq_valid, 1);
            check_val("t1_req_addr", ireq_addr, RST_PC + 32'(4 * (i - 1)));
            if (i >= 3) begin
                check_val("t1_out_valid", out_valid, 1);
                check_val("t1_out_pc", out_pc, RST_PC + 32'(4 * (i - 3)));
                check_val("t1_out_instr", out_instr, instr_of(RST_PC + 32'(4 * (i - 3))));
            end else begin
                check_val("t1_out_valid_early", out_valid, 0);
            end
        end

        // Decode stalled: exactly DEPTH words, then issue stops until a pop frees a slot.
        do_reset();
        set_addr_ok(1);
        auto_resp = 1;
        out_ready = 0;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check_val("t2_req_stopped", ireq_valid, 0);
            check_val("t2_out_valid", out_valid, 1);
            check_val("t2_head_pc", out_pc, RST_PC);
            tick();
        end
        out_ready = 1;
        exp_q = '{RST_PC + 32'd4, RST_PC + 32'd8, RST_PC + 32'd12, RST_PC + 32'd16};
        tick();
        check_val("t2_reissue_valid", ireq_valid, 1);
        check_val("t2_reissue_addr", ireq_addr, RST_PC + 32'h10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check_val("t2_drain_valid", out_valid, 1);
            check_val("t2_drain_pc", out_pc, exp_q.pop_front());
        end

        // Request held stable while addr_ok stays low.
        do_reset();
        set_addr_ok(0);
        auto_resp = 1;
        out_ready = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_val("t3_hold_valid", ireq_valid, 1);
            check_val("t3_hold_addr", ireq_addr, RST_PC);
            if (i < 5) tick();
        end
        set_addr_ok(1);
        tick();
        check_val("t3_next_addr", ireq_addr, RST_PC + 32'd4);

        // Redirect with two reads in flight: both responses dropped.
        do_reset();
        set_addr_ok(1);
        auto_resp = 0;
        out_ready = 1;
        tick();
        tick();
        tick();
        check_val("t4_credit_stall", ireq_valid, 0);
        redirect_valid = 1;
        redirect_pc    = 32'h8000_1000;
        tick();
        check_val("t4_flush_out_valid", out_valid, 0);
        check_val("t4_flush_req_valid", ireq_valid, 0);
        auto_resp = 1;
        drive_resp();
        tick();
        check_val("t4_drop1_out_valid", out_valid, 0);
        check_val("t4_new_req_valid", ireq_valid, 1);
        check_val("t4_new_req_addr", ireq_addr, 32'h8000_1000);
        tick();
        check_val("t4_drop2_out_valid", out_valid, 0);
        check_val("t4_next_req_addr", ireq_addr, 32'h8000_1004);
        tick();
        check_val("t4_first_valid", out_valid, 1);
        check_val("t4_first_pc", out_pc, 32'h8000_1000);
        check_val("t4_first_instr", out_instr, instr_of(32'h8000_1000));
        tick();
        check_val("t4_second_pc", out_pc, 32'h8000_1004);

        // Redirect while bfc00008 waits for acceptance.
        do_reset();
        set_addr_ok(1);
        auto_resp = 1;
        out_ready = 1;
        tick();
        tick();
        tick();
        check_val("t5_pending_addr", ireq_addr, RST_PC + 32'd8);
        set_addr_ok(0);
        redirect_valid = 1;
        redirect_pc    = 32'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t5_held_valid", ireq_valid, 1);
            check_val("t5_held_addr", ireq_addr, RST_PC + 32'd8);
            check_val("t5_held_out_valid", out_valid, 0);
        end
        set_addr_ok(1);
        tick();
        check_val("t5_redirect_addr", ireq_addr, 32'h8000_2000);
        check_val("t5_after_acc_out_valid", out_valid, 0);
        tick();
        check_val("t5_killed_dropped", out_valid, 0);
        tick();
        check_val("t5_first_valid", out_valid, 1);
        check_val("t5_first_pc", out_pc, 32'h8000_2000);

        // Redirect coinciding with data_ok, accept and pop; then reset mid-burst.
        do_reset();
        set_addr_ok(1);
        auto_resp = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        check_val("t6_pre_pc", out_pc, RST_PC + 32'd4);
        check_val("t6_pre_data_ok", iresp_data_ok, 1);
        redirect_valid = 1;
        redirect_pc    = 32'h8000_3000;
        tick();
        check_val("t6_flush_out_valid", out_valid, 0);
        check_val("t6_redir_req_valid", ireq_valid, 1);
        check_val("t6_redir_req_addr", ireq_addr, 32'h8000_3000);
        tick();
        check_val("t6_kill_out_valid", out_valid, 0);
        tick();
        check_val("t6_first_valid", out_valid, 1);
        check_val("t6_first_pc", out_pc, 32'h8000_3000);
        tick();
        tick();
        reset         = 1;
        auto_resp     = 0;
        iresp_data_ok = 0;
        #1;
        check_val("t6_async_req_valid", ireq_valid, 0);
        check_val("t6_async_req_addr", ireq_addr, RST_PC);
        check_val("t6_async_out_valid", out_valid, 0);
        check_val("t6_async_out_pc", out_pc, 0);
        bus_q.delete();
        tick();
        tick();
        reset = 0;
        set_addr_ok(1);
        auto_resp = 1;
        tick();
        check_val("t6_restart_valid", ireq_valid, 1);
        check_val("t6_restart_addr", ireq_addr, RST_PC);
        tick();
        tick();
        check_val("t6_restart_out_valid", out_valid, 1);
        check_val("t6_restart_out_pc", out_pc, RST_PC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
